// File: rtl/mult_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiplier: ALU control codes and FSM state encoding.
package mult_hilo_unit_pkg;

  localparam logic [5:0] ALUCTRL_AND   = 6'h00;
  localparam logic [5:0] ALUCTRL_OR    = 6'h01;
  localparam logic [5:0] ALUCTRL_ADD   = 6'h02;
  localparam logic [5:0] ALUCTRL_SUB   = 6'h06;
  localparam logic [5:0] ALUCTRL_SLT   = 6'h07;
  localparam logic [5:0] ALUCTRL_MULTU = 6'h13;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mult_step.sv
// One radix-2 shift-add iteration: conditional add of the multiplicand into the upper
// accumulator, then shift {carry,acc,mplier} right by one.
module mult_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mplier,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mplier_nxt
);

  logic [WIDTH:0] sum;

  // Carry of the add lands in the accumulator MSB after the shift.
  assign sum        = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign acc_nxt    = sum[WIDTH:1];
  assign mplier_nxt = {sum[0], mplier[WIDTH-1:1]};

endmodule

// File: rtl/mult_hilo_unit.sv
// Multi-cycle unsigned multiplier with HI/LO registers; stalls the pipeline while a MULTU
// iterates and commits the full product into HI/LO on the final iteration edge.
module mult_hilo_unit
  import mult_hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       alu_ctrl,
  input  logic             issue,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall,
  output logic             done
);

  mul_state_e       state, state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mplier_nxt;
  logic             start;
  logic             last;

  assign start = issue & (alu_ctrl == ALUCTRL_MULTU) & ~flush;
  assign last  = (count == CNT_W'(WIDTH-1));

  mult_step #(.WIDTH(WIDTH)) u_step (
    .mcand      (mcand),
    .acc        (acc),
    .mplier     (mplier),
    .acc_nxt    (acc_nxt),
    .mplier_nxt (mplier_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MUL_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      MUL_IDLE: begin
        stall = start;
        if (start) state_nxt = MUL_RUN;
      end
      MUL_RUN: begin
        stall = 1'b1;
        // A flush on the final iteration still wins: nothing is committed.
        if (flush)     state_nxt = MUL_IDLE;
        else if (last) state_nxt = MUL_DONE;
      end
      MUL_DONE: begin
        done      = 1'b1;
        state_nxt = MUL_IDLE;
      end
      default: state_nxt = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            count  <= '0;
          end else begin
            if (mthi) hi <= op_a;
            if (mtlo) lo <= op_a;
          end
        end
        MUL_RUN: begin
          if (!flush) begin
            acc    <= acc_nxt;
            mplier <= mplier_nxt;
            count  <= count + CNT_W'(1);
            if (last) begin
              hi <= acc_nxt;
              lo <= mplier_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed and randomized bench for mult_hilo_unit against a plain-arithmetic HI/LO model.
module tb_mult_hilo_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  alu_ctrl;
  logic        issue;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;
  logic        done;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_ctrl (alu_ctrl),
    .issue    (issue),
    .flush    (flush),
    .op_a     (op_a),
    .op_b     (op_b),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .hi       (hi),
    .lo       (lo),
    .stall    (stall),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a MULTU at the current cycle t and follows it to the DONE cycle t+33.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit poke_lo);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    alu_ctrl = 6'h13; issue = 1'b1; op_a = a; op_b = b;
    #1;
    chk("stall_issue", 64'(stall), 64'd1);
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      mtlo = poke_lo && (i <= 3);
      #1;
      chk("stall_run", 64'(stall), 64'd1);
      chk("done_run", 64'(done), 64'd0);
      chk("hi_run", 64'(hi), 64'(m_hi));
      chk("lo_run", 64'(lo), 64'(m_lo));
    end
    tick();
    mtlo = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("stall_done", 64'(stall), 64'd0);
    m_hi = p[63:32];
    m_lo = p[31:0];
    chk("hi_prod", 64'(hi), 64'(m_hi));
    chk("lo_prod", 64'(lo), 64'(m_lo));
    issue = 1'b0; alu_ctrl = 6'h00;
    tick();
    chk("done_after", 64'(done), 64'd0);
    chk("stall_after", 64'(stall), 64'd0);
  endtask

  initial begin
    reset = 1'b1; alu_ctrl = 6'h00; issue = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0; mthi = 1'b0; mtlo = 1'b0;
    m_hi = '0; m_lo = '0;
    tick(); tick();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    // mthi in IDLE
    op_a = 32'hDEADBEEF; mthi = 1'b1;
    tick();
    mthi = 1'b0; m_hi = 32'hDEADBEEF;
    chk("mthi_hi", 64'(hi), 64'(m_hi));
    chk("mthi_lo", 64'(lo), 64'(m_lo));

    // Reset mid-RUN clears hi/lo
    op_a = 32'h1111_2222; mtlo = 1'b1;
    tick();
    mtlo = 1'b0; m_lo = 32'h1111_2222;
    chk("mtlo_lo", 64'(lo), 64'(m_lo));
    alu_ctrl = 6'h13; issue = 1'b1; op_a = 32'h1234; op_b = 32'h5678;
    for (int i = 0; i < 5; i++) tick();
    issue = 1'b0; alu_ctrl = 6'h00;
    reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    chk("rstrun_hi", 64'(hi), 64'd0);
    chk("rstrun_lo", 64'(lo), 64'd0);
    chk("rstrun_stall", 64'(stall), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rstrun_idle_stall", 64'(stall), 64'd0);
    chk("rstrun_idle_done", 64'(done), 64'd0);

    // Full-scale, small and zero-operand products; mtlo poked during RUN
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("maxhi", 64'(hi), 64'hFFFFFFFE);
    chk("maxlo", 64'(lo), 64'h00000001);
    do_mul(32'd7, 32'd6, 1'b1);
    chk("sevsix_lo", 64'(lo), 64'd42);
    do_mul(32'd0, 32'h12345678, 1'b0);
    chk("zero_hi", 64'(hi), 64'd0);

    // Flush during RUN with hi/lo preloaded
    op_a = 32'hA; mthi = 1'b1;
    tick();
    op_a = 32'hB; mthi = 1'b0; mtlo = 1'b1;
    tick();
    mtlo = 1'b0; m_hi = 32'hA; m_lo = 32'hB;
    alu_ctrl = 6'h13; issue = 1'b1; op_a = 32'hFFFF; op_b = 32'hFFFF;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    #1;
    chk("flush_stall_run", 64'(stall), 64'd1);
    tick();
    flush = 1'b0; issue = 1'b0; alu_ctrl = 6'h00;
    #1;
    chk("flush_idle_stall", 64'(stall), 64'd0);
    chk("flush_hi", 64'(hi), 64'hA);
    chk("flush_lo", 64'(lo), 64'hB);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("flush_nodone", 64'(done), 64'd0);
    end
    chk("flush_hi_late", 64'(hi), 64'hA);
    chk("flush_lo_late", 64'(lo), 64'hB);

    // Non-MULTU control and MULTU without issue
    alu_ctrl = 6'h02; issue = 1'b1; op_a = 32'h5; op_b = 32'h6;
    #1;
    chk("nonmul_stall", 64'(stall), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nonmul_stall_c", 64'(stall), 64'd0);
      chk("nonmul_done", 64'(done), 64'd0);
    end
    alu_ctrl = 6'h13; issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("noissue_stall", 64'(stall), 64'd0);
    end
    chk("nonmul_hi", 64'(hi), 64'(m_hi));
    chk("nonmul_lo", 64'(lo), 64'(m_lo));
    alu_ctrl = 6'h00;

    // Randomized products against 64-bit arithmetic
    for (int n = 0; n < 6; n++) begin
      do_mul($urandom, $urandom, (n % 2) == 1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
